// File: rtl/rv_dmem_responder.sv
// Data-memory responder for the uRV load/store handshake: word RAM with a
// fixed number of wait states, one-cycle done pulses and a sticky overrun flag.
module rv_dmem_responder #(
  parameter int g_ADDR_WIDTH  = 12,
  parameter int g_WAIT_STATES = 1
) (
  input  logic        clk_i,
  input  logic        rst_n_i,
  input  logic [31:0] dm_addr_i,
  input  logic [31:0] dm_data_s_i,
  input  logic [3:0]  dm_data_select_i,
  input  logic        dm_load_i,
  input  logic        dm_store_i,
  output logic [31:0] dm_data_l_o,
  output logic        dm_load_done_o,
  output logic        dm_store_done_o,
  output logic        dm_busy_o,
  output logic        dm_overrun_o
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic [3:0] WAIT_INIT = (g_WAIT_STATES == 0) ? 4'd0 : 4'(g_WAIT_STATES - 1);

  state_t                    state_q, state_d;
  logic [3:0]                cnt_q, cnt_d;
  logic                      is_store_q, is_store_d;
  logic [g_ADDR_WIDTH-1:0]   idx_q, idx_d;
  logic [31:0]               wdata_q, wdata_d;
  logic [3:0]                mask_q, mask_d;
  logic [31:0]               data_l_q, data_l_d;
  logic                      load_done_q, load_done_d;
  logic                      store_done_q, store_done_d;
  logic                      overrun_q, overrun_d;

  logic                      req_s;
  logic                      acc_s;
  logic                      commit_s;
  logic                      eff_store_s;
  logic [g_ADDR_WIDTH-1:0]   eff_idx_s;
  logic [31:0]               eff_wdata_s;
  logic [3:0]                eff_mask_s;
  logic                      wr_en_s;
  logic                      unused_s;

  logic [31:0] mem [0:(1 << g_ADDR_WIDTH)-1];

  assign req_s    = dm_load_i | dm_store_i;
  assign unused_s = ^{dm_addr_i[31:g_ADDR_WIDTH+2], dm_addr_i[1:0]};

  // Next-state, wait counter, request capture and overrun detection.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    is_store_d = is_store_q;
    idx_d      = idx_q;
    wdata_d    = wdata_q;
    mask_d     = mask_q;
    overrun_d  = overrun_q;
    acc_s      = 1'b0;
    case (state_q)
      IDLE: begin
        acc_s = req_s;
      end
      WAIT: begin
        overrun_d = overrun_q | req_s;
        if (cnt_q == 4'd0) begin
          state_d = DONE;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      DONE: begin
        acc_s = req_s;
        if (!req_s) begin
          state_d = IDLE;
        end else begin
          state_d = DONE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
    if (acc_s) begin
      // A simultaneous load+store keeps the store and flags the lost load.
      is_store_d = dm_store_i;
      idx_d      = dm_addr_i[g_ADDR_WIDTH+1:2];
      wdata_d    = dm_data_s_i;
      mask_d     = dm_data_select_i;
      overrun_d  = overrun_q | (dm_load_i & dm_store_i);
      if (g_WAIT_STATES == 0) begin
        state_d = DONE;
      end else begin
        state_d = WAIT;
        cnt_d   = WAIT_INIT;
      end
    end else begin
      is_store_d = is_store_q;
    end
  end

  // With zero wait states the accept edge is also the commit edge, so the
  // live request fields must bypass the capture registers.
  always_comb begin
    eff_store_s  = acc_s ? dm_store_i                      : is_store_q;
    eff_idx_s    = acc_s ? dm_addr_i[g_ADDR_WIDTH+1:2]     : idx_q;
    eff_wdata_s  = acc_s ? dm_data_s_i                     : wdata_q;
    eff_mask_s   = acc_s ? dm_data_select_i                : mask_q;
    commit_s     = (state_d == DONE);
    wr_en_s      = commit_s & eff_store_s & rst_n_i;
    load_done_d  = commit_s & ~eff_store_s;
    store_done_d = commit_s & eff_store_s;
    if (commit_s && !eff_store_s) begin
      data_l_d = mem[eff_idx_s];
    end else begin
      data_l_d = data_l_q;
    end
  end

  // Control and output registers.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q      <= IDLE;
      cnt_q        <= 4'd0;
      is_store_q   <= 1'b0;
      idx_q        <= '0;
      wdata_q      <= 32'd0;
      mask_q       <= 4'd0;
      data_l_q     <= 32'd0;
      load_done_q  <= 1'b0;
      store_done_q <= 1'b0;
      overrun_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      is_store_q   <= is_store_d;
      idx_q        <= idx_d;
      wdata_q      <= wdata_d;
      mask_q       <= mask_d;
      data_l_q     <= data_l_d;
      load_done_q  <= load_done_d;
      store_done_q <= store_done_d;
      overrun_q    <= overrun_d;
    end
  end

  // RAM byte-lane write; contents survive reset.
  always_ff @(posedge clk_i) begin
    if (wr_en_s) begin
      for (int i = 0; i < 4; i++) begin
        if (eff_mask_s[i]) begin
          mem[eff_idx_s][8*i +: 8] <= eff_wdata_s[8*i +: 8];
        end
      end
    end
  end

  assign dm_data_l_o     = data_l_q;
  assign dm_load_done_o  = load_done_q;
  assign dm_store_done_o = store_done_q;
  assign dm_busy_o       = (state_q == WAIT);
  assign dm_overrun_o    = overrun_q;

endmodule

// File: tb/tb_rv_dmem_responder.sv
// Self-checking bench: three responders (0, 1 and 3 wait states) driven from a
// vector table and hand sequences, with completions checked against a scoreboard.
module tb_rv_dmem_responder;

  typedef struct {
    int          d;
    bit          ld;
    bit          st;
    logic [31:0] addr;
    logic [31:0] data;
    logic [3:0]  mask;
    logic [31:0] exp;
  } vec_t;

  typedef struct {
    int          d;
    bit          is_load;
    logic [31:0] data;
    int          cyc;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  int          cyc = 0;
  int          n_tests = 0;
  int          n_fail = 0;
  int          wst [3] = '{0, 1, 3};

  logic [31:0] addr_i [3];
  logic [31:0] ds_i   [3];
  logic [3:0]  sel_i  [3];
  logic        ld_i   [3];
  logic        st_i   [3];
  logic [31:0] data_l [3];
  logic        ldd    [3];
  logic        std    [3];
  logic        busy   [3];
  logic        ovr    [3];

  exp_t        sbq [$];
  logic [31:0] last_load [3];
  vec_t        vecs [13];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  rv_dmem_responder #(.g_ADDR_WIDTH(12), .g_WAIT_STATES(0)) u_w0 (
    .clk_i(clk), .rst_n_i(rst_n), .dm_addr_i(addr_i[0]), .dm_data_s_i(ds_i[0]),
    .dm_data_select_i(sel_i[0]), .dm_load_i(ld_i[0]), .dm_store_i(st_i[0]),
    .dm_data_l_o(data_l[0]), .dm_load_done_o(ldd[0]), .dm_store_done_o(std[0]),
    .dm_busy_o(busy[0]), .dm_overrun_o(ovr[0]));

  rv_dmem_responder #(.g_ADDR_WIDTH(12), .g_WAIT_STATES(1)) u_w1 (
    .clk_i(clk), .rst_n_i(rst_n), .dm_addr_i(addr_i[1]), .dm_data_s_i(ds_i[1]),
    .dm_data_select_i(sel_i[1]), .dm_load_i(ld_i[1]), .dm_store_i(st_i[1]),
    .dm_data_l_o(data_l[1]), .dm_load_done_o(ldd[1]), .dm_store_done_o(std[1]),
    .dm_busy_o(busy[1]), .dm_overrun_o(ovr[1]));

  rv_dmem_responder #(.g_ADDR_WIDTH(12), .g_WAIT_STATES(3)) u_w3 (
    .clk_i(clk), .rst_n_i(rst_n), .dm_addr_i(addr_i[2]), .dm_data_s_i(ds_i[2]),
    .dm_data_select_i(sel_i[2]), .dm_load_i(ld_i[2]), .dm_store_i(st_i[2]),
    .dm_data_l_o(data_l[2]), .dm_load_done_o(ldd[2]), .dm_store_done_o(std[2]),
    .dm_busy_o(busy[2]), .dm_overrun_o(ovr[2]));

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic idle_all();
    for (int d = 0; d < 3; d++) begin
      ld_i[d] = 1'b0; st_i[d] = 1'b0; addr_i[d] = 32'd0; ds_i[d] = 32'd0; sel_i[d] = 4'd0;
    end
  endtask

  task automatic drive(input int d, input bit ld, input bit st, input logic [31:0] a,
                       input logic [31:0] dat, input logic [3:0] m, input logic [31:0] e,
                       input bit push);
    exp_t x;
    ld_i[d] = ld; st_i[d] = st; addr_i[d] = a; ds_i[d] = dat; sel_i[d] = m;
    if (push) begin
      x.d = d; x.is_load = !st; x.data = e; x.cyc = cyc + 1 + wst[d];
      sbq.push_back(x);
    end
  endtask

  task automatic drain();
    for (int i = 0; i < 40; i++) begin
      @(negedge clk); #1;
      if (sbq.size() == 0) break;
    end
    n_tests++;
    if (sbq.size() != 0) begin
      n_fail++;
      $display("FAIL drain_timeout: %0d completions outstanding, expected 0", sbq.size());
      sbq.delete();
    end
  endtask

  task automatic req(input vec_t v);
    @(negedge clk);
    drive(v.d, v.ld, v.st, v.addr, v.data, v.mask, v.exp, 1'b1);
    @(negedge clk);
    idle_all();
    drain();
  endtask

  // Completion monitor: every done pulse must match the head of the scoreboard.
  always @(negedge clk) begin
    exp_t e;
    if (rst_n) begin
      for (int d = 0; d < 3; d++) begin
        if (ldd[d] || std[d]) begin
          chk("done_exclusive", {31'd0, ldd[d] & std[d]}, 32'd0);
          if (sbq.size() == 0) begin
            chk("unexpected_done", {31'd0, 1'b1}, 32'd0);
          end else begin
            e = sbq.pop_front();
            chk("done_dut", d, e.d);
            chk("done_kind", {31'd0, ldd[d]}, {31'd0, e.is_load});
            chk("done_cycle", cyc, e.cyc);
            if (e.is_load) begin
              chk("load_data", data_l[d], e.data);
              last_load[d] = e.data;
            end else begin
              chk("store_holds_data", data_l[d], last_load[d]);
            end
          end
        end
      end
    end
  end

  initial begin
    vecs[0]  = '{1, 1'b0, 1'b1, 32'h40,        32'hDEADBEEF, 4'hF,    32'h0};
    vecs[1]  = '{1, 1'b1, 1'b0, 32'h40,        32'h0,        4'h0,    32'hDEADBEEF};
    vecs[2]  = '{1, 1'b0, 1'b1, 32'h10,        32'h11223344, 4'hF,    32'h0};
    vecs[3]  = '{1, 1'b0, 1'b1, 32'h10,        32'hAABBCCDD, 4'b0101, 32'h0};
    vecs[4]  = '{1, 1'b1, 1'b0, 32'h10,        32'h0,        4'h0,    32'h11BB33DD};
    vecs[5]  = '{1, 1'b0, 1'b1, 32'h0000_4004, 32'h0000CAFE, 4'hF,    32'h0};
    vecs[6]  = '{1, 1'b1, 1'b0, 32'h4,         32'h0,        4'h0,    32'h0000CAFE};
    vecs[7]  = '{1, 1'b1, 1'b0, 32'h7,         32'h0,        4'h0,    32'h0000CAFE};
    vecs[8]  = '{1, 1'b0, 1'b1, 32'h20,        32'h12345678, 4'hF,    32'h0};
    vecs[9]  = '{1, 1'b0, 1'b1, 32'h20,        32'hFFFFFFFF, 4'h0,    32'h0};
    vecs[10] = '{1, 1'b1, 1'b0, 32'h20,        32'h0,        4'h0,    32'h12345678};
    vecs[11] = '{2, 1'b0, 1'b1, 32'h0,         32'h00000099, 4'hF,    32'h0};
    vecs[12] = '{2, 1'b1, 1'b0, 32'h3,         32'h0,        4'h0,    32'h00000099};

    idle_all();
    for (int d = 0; d < 3; d++) last_load[d] = 32'd0;
    #12;
    for (int d = 0; d < 3; d++) begin
      chk("reset_data_l",     data_l[d],         32'd0);
      chk("reset_load_done",  {31'd0, ldd[d]},   32'd0);
      chk("reset_store_done", {31'd0, std[d]},   32'd0);
      chk("reset_busy",       {31'd0, busy[d]},  32'd0);
      chk("reset_overrun",    {31'd0, ovr[d]},   32'd0);
    end
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 13; i++) req(vecs[i]);
    chk("w1_overrun_clear", {31'd0, ovr[1]}, 32'd0);

    // Zero wait states: load issued during the store's DONE cycle sees new data.
    @(negedge clk);
    drive(0, 1'b0, 1'b1, 32'h8, 32'h5, 4'hF, 32'h0, 1'b1);
    @(negedge clk);
    drive(0, 1'b1, 1'b0, 32'h8, 32'h0, 4'h0, 32'h5, 1'b1);
    @(negedge clk);
    idle_all();
    drain();
    chk("w0_overrun_clear", {31'd0, ovr[0]}, 32'd0);

    // Three wait states: second load during WAIT is dropped and flags overrun.
    @(negedge clk);
    drive(2, 1'b1, 1'b0, 32'h0, 32'h0, 4'h0, 32'h99, 1'b1);
    @(negedge clk);
    drive(2, 1'b1, 1'b0, 32'h10, 32'h0, 4'h0, 32'h0, 1'b0);
    chk("w3_busy", {31'd0, busy[2]}, 32'd1);
    @(negedge clk);
    idle_all();
    drain();
    chk("w3_overrun_set", {31'd0, ovr[2]}, 32'd1);
    repeat (5) @(negedge clk);
    chk("w3_overrun_sticky", {31'd0, ovr[2]}, 32'd1);

    // Load and store together: store wins, overrun set.
    @(negedge clk);
    drive(1, 1'b1, 1'b1, 32'h80, 32'h77, 4'hF, 32'h0, 1'b1);
    @(negedge clk);
    idle_all();
    drain();
    chk("w1_dual_overrun", {31'd0, ovr[1]}, 32'd1);
    req('{1, 1'b1, 1'b0, 32'h80, 32'h0, 4'h0, 32'h77});

    // Reset during WAIT of a store aborts it without writing.
    @(negedge clk);
    drive(1, 1'b0, 1'b1, 32'h20, 32'hFFFFFFFF, 4'hF, 32'h0, 1'b0);
    @(negedge clk);
    idle_all();
    chk("w1_busy_wait", {31'd0, busy[1]}, 32'd1);
    rst_n = 1'b0;
    #1;
    chk("abort_data_l",     data_l[1],        32'd0);
    chk("abort_load_done",  {31'd0, ldd[1]},  32'd0);
    chk("abort_store_done", {31'd0, std[1]},  32'd0);
    chk("abort_busy",       {31'd0, busy[1]}, 32'd0);
    chk("abort_overrun",    {31'd0, ovr[1]},  32'd0);
    chk("abort_overrun_w3", {31'd0, ovr[2]},  32'd0);
    for (int d = 0; d < 3; d++) last_load[d] = 32'd0;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    req('{1, 1'b1, 1'b0, 32'h20, 32'h0, 4'h0, 32'h12345678});
    chk("sb_empty_end", sbq.size(), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/rv_dmem_responder.md
# rv_dmem_responder

Data-memory responder for the uRV core: the memory end of the load/store handshake that the writeback stage consumes. It accepts single-cycle load/store request pulses from the execute stage and services them from an internal word-organised RAM with a programmable number of wait states. It returns `dm_data_l_o` with a one-cycle `dm_load_done_o` or `dm_store_done_o` pulse. It sits between the execute/writeback pipeline and the on-chip data RAM, and lets the core's pending-load/store stall logic be exercised with realistic latencies.

## Interface
- `g_ADDR_WIDTH`, default 12: word-address bits; RAM depth is 2^g_ADDR_WIDTH × 32 bits.
- `g_WAIT_STATES`, default 1: extra cycles before completion, legal range 0..15.
- `clk_i` in 1: single clock; all logic on its rising edge.
- `rst_n_i` in 1: reset, asynchronous, active-low.
- `dm_addr_i` in 32: byte address of the request.
- `dm_data_s_i` in 32: store data, already lane-aligned by the initiator.
- `dm_data_select_i` in 4: byte-lane write enables; bit n enables bits [8n+7:8n].
- `dm_load_i` in 1: load request pulse.
- `dm_store_i` in 1: store request pulse.
- `dm_data_l_o` out 32: full word read; lane extraction is done downstream.
- `dm_load_done_o` out 1: one-cycle load completion pulse.
- `dm_store_done_o` out 1: one-cycle store completion pulse.
- `dm_busy_o` out 1: high while a request is outstanding and not completing this cycle.
- `dm_overrun_o` out 1: sticky; set when a request arrives while busy.

## Operation
- FSM states: IDLE, WAIT, DONE.
  - IDLE: a request is accepted on the edge where `dm_load_i` or `dm_store_i` is high.
    - If g_WAIT_STATES = 0, go to DONE.
    - Otherwise load the wait counter with g_WAIT_STATES-1 and go to WAIT.
  - WAIT: decrement the counter each cycle; go to DONE when the counter is 0.
  - DONE: assert the matching done pulse for exactly one cycle.
    - A request present in this cycle is accepted (back-to-back) and follows the IDLE rules above.
    - With no request present, return to IDLE.
- Acceptance latches the request type, the word index `dm_addr_i[g_ADDR_WIDTH+1:2]`, the store data and the lane mask.
  - `dm_addr_i[1:0]` is ignored.
  - Address bits above g_ADDR_WIDTH+1 are ignored, so addresses alias modulo the RAM size.
- Store: the RAM write of the enabled lanes happens on the edge that enters DONE.
  - Mask 4'b0000 writes nothing but still completes with `dm_store_done_o`.
- Load: the RAM word is registered into `dm_data_l_o` on the edge that enters DONE.
  - The value is held until the next load completes; stores do not change it.
- Load and store high in the same accept cycle: the store is serviced, the load is dropped, and `dm_overrun_o` is set.
- A request in a WAIT cycle, or in a DONE cycle while another request is also being accepted, is ignored and sets `dm_overrun_o`.
- `dm_busy_o` = (state == WAIT).

## Timing
- Reset values (asynchronous): state IDLE; counter 0; `dm_data_l_o` = 0; both done pulses, `dm_busy_o` and `dm_overrun_o` = 0. RAM contents are not reset.
- Latency: a request sampled at edge k produces its done pulse in the cycle following edge k+g_WAIT_STATES.
  - g_WAIT_STATES = 0 gives the done pulse in the cycle right after acceptance.
- Throughput: one request per g_WAIT_STATES+1 cycles, with back-to-back acceptance during DONE.
- `dm_data_l_o` is valid in the same cycle as `dm_load_done_o` and stays stable after it.
- Read-after-write: a load accepted during the store's DONE cycle returns the newly written data.
- Reset asserted mid-request: the request is aborted, no done pulse is issued, and any store not yet committed is not written.
- Done pulses never last more than one cycle. `dm_load_done_o` and `dm_store_done_o` are never high together.

## Test plan
- g_WAIT_STATES=1: store 32'hDEADBEEF to 0x40 with mask 4'hF (`dm_store_done_o` two cycles after the request edge), then load 0x40 → `dm_load_done_o` two cycles later with `dm_data_l_o` = 32'hDEADBEEF.
- Byte lanes: preload 0x10 = 32'h11223344, store 32'hAABBCCDD with mask 4'b0101 → a subsequent load returns 32'h11BB33DD.
- g_WAIT_STATES=0 back-to-back: a store to 0x8 (32'h5) followed by a load of 0x8 requested during the store's DONE cycle → load done one cycle later with data 32'h5. Overrun stays 0.
- Overrun: g_WAIT_STATES=3, issue a load, then a second load one cycle later → only one `dm_load_done_o`, 4 cycles after the first request, and `dm_overrun_o` = 1 until reset.
- Aliasing: with g_ADDR_WIDTH=12, store 32'hCAFE to 0x0000_4004 → a load from 0x4 returns 32'hCAFE. A load with `dm_addr_i[1:0]` = 2'b11 returns the same word.
- Reset: assert `rst_n_i` low during WAIT of a store to 0x20 → no done pulse, all outputs 0 immediately, and a later load of 0x20 returns its pre-store value.
